bridge_input_conditioner: RTL



---
 rtl/bridge_input_conditioner_if.sv | 28 ++
 rtl/bridge_input_conditioner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bridge_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_input_conditioner_if
//  Description : Front-panel control bundle between hps_io and the input
//                conditioner: raw PS/2 key event and joystick word in,
//                debounced 12-bit button word out.
//  Revision    : 1.0  initial release
// ============================================================================
interface bridge_input_conditioner_if;
    logic [10:0] ps2_key;   // [10] toggle, [9] pressed, [8] extended, [7:0] code
    logic [15:0] joystick;  // hps_io joystick_0
    logic [11:0] inputs;    // debounced, registered, active-high buttons

    // Producer side (hps_io / testbench)
    modport master (
        output ps2_key,
        output joystick,
        input  inputs
    );

    // Conditioner side
    modport slave (
        input  ps2_key,
        input  joystick,
        output inputs
    );
endinterface
`default_nettype wire

// File: rtl/bridge_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_input_conditioner
//  Description : Turns PS/2 key events into held key states, ORs them with
//                the joystick buttons and debounces each of the 12 buttons on
//                a divided tick before presenting the registered inputs word.
//  Revision    : 1.0  initial release
// ============================================================================
module bridge_input_conditioner #(
    parameter int TICK_DIV       = 42954,  // clk cycles per debounce tick, >= 2
    parameter int DEBOUNCE_TICKS = 4       // ticks a change must hold, 1..15
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    bridge_input_conditioner_if.slave bus
);

    localparam int                  c_NBTN      = 12;
    localparam int                  c_TICK_W    = $clog2(TICK_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [3:0]          c_DEB_TICKS = 4'(DEBOUNCE_TICKS);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                r_toggle_prev;
    logic [c_NBTN-1:0]   r_keys;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [3:0]          r_deb_cnt [c_NBTN];
    logic [c_NBTN-1:0]   r_inputs;

    logic                w_event;
    logic [c_NBTN-1:0]   w_key_mask;
    logic [c_NBTN-1:0]   w_joy_map;
    logic [c_NBTN-1:0]   w_raw;
    logic                w_tick;
    logic [3:0]          w_deb_nxt [c_NBTN];
    logic [c_NBTN-1:0]   w_inputs_nxt;
    logic                w_unused_joy;

    // ------------------------------------------------------------------
    // Key event capture
    // ------------------------------------------------------------------
    // A flip of the toggle bit marks a new key event; extended codes are
    // never decoded.
    assign w_event = (bus.ps2_key[10] != r_toggle_prev) && !bus.ps2_key[8];

    // Scan code to one-hot button mask; unknown codes give an empty mask.
    always_comb begin
        w_key_mask = '0;
        case (bus.ps2_key[7:0])
            8'h1C:   w_key_mask[0]  = 1'b1;  // pass
            8'h1A:   w_key_mask[1]  = 1'b1;  // spades
            8'h2A:   w_key_mask[2]  = 1'b1;  // clubs
            8'h2B:   w_key_mask[3]  = 1'b1;  // rdbl
            8'h1B:   w_key_mask[4]  = 1'b1;  // NT
            8'h22:   w_key_mask[5]  = 1'b1;  // hearts/up
            8'h14:   w_key_mask[6]  = 1'b1;  // play/yes
            8'h66:   w_key_mask[7]  = 1'b1;  // back
            8'h23:   w_key_mask[8]  = 1'b1;  // dbl
            8'h21:   w_key_mask[9]  = 1'b1;  // diamonds/down
            8'h16:   w_key_mask[10] = 1'b1;  // start
            8'h11:   w_key_mask[11] = 1'b1;  // play/no
            default: w_key_mask     = '0;
        endcase
    end

    // Track the toggle bit and load the addressed key-state bit with the
    // pressed flag. Reset captures the live toggle so no event follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_toggle_prev <= bus.ps2_key[10];
            r_keys        <= '0;
        end else begin
            r_toggle_prev <= bus.ps2_key[10];
            if (w_event) begin
                r_keys <= (r_keys & ~w_key_mask)
                        | (w_key_mask & {c_NBTN{bus.ps2_key[9]}});
            end
        end
    end

    // ------------------------------------------------------------------
    // Joystick map and merge
    // ------------------------------------------------------------------
    // Every button owns a distinct joystick bit; the top nibble is spare.
    assign w_joy_map = {
        bus.joystick[11],   // 11 play/no
        bus.joystick[8],    // 10 start
        bus.joystick[2],    //  9 diamonds/down
        bus.joystick[6],    //  8 dbl
        bus.joystick[9],    //  7 back
        bus.joystick[10],   //  6 play/yes
        bus.joystick[3],    //  5 hearts/up
        bus.joystick[5],    //  4 NT
        bus.joystick[7],    //  3 rdbl
        bus.joystick[0],    //  2 clubs
        bus.joystick[1],    //  1 spades
        bus.joystick[4]     //  0 pass
    };

    assign w_unused_joy = &{1'b0, bus.joystick[15:12]};

    // Either source holds a button down until both let go.
    assign w_raw = r_keys | w_joy_map;

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // Free-running divider that wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce
    // ------------------------------------------------------------------
    // Agreement clears the count at once; disagreement counts ticks and
    // the output follows raw when the count reaches DEBOUNCE_TICKS.
    always_comb begin
        w_inputs_nxt = r_inputs;
        for (int i = 0; i < c_NBTN; i++) begin
            w_deb_nxt[i] = r_deb_cnt[i];
            if (w_raw[i] == r_inputs[i]) begin
                w_deb_nxt[i] = 4'd0;
            end else if (w_tick) begin
                if ((r_deb_cnt[i] + 4'd1) == c_DEB_TICKS) begin
                    w_deb_nxt[i]    = 4'd0;
                    w_inputs_nxt[i] = w_raw[i];
                end else begin
                    w_deb_nxt[i] = r_deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Debounce counters and the output word; reset abandons any count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inputs <= '0;
            for (int i = 0; i < c_NBTN; i++) begin
                r_deb_cnt[i] <= 4'd0;
            end
        end else begin
            r_inputs <= w_inputs_nxt;
            for (int i = 0; i < c_NBTN; i++) begin
                r_deb_cnt[i] <= w_deb_nxt[i];
            end
        end
    end

    assign bus.inputs = r_inputs;

endmodule
`default_nettype wire
